// File: rtl/ddram_resp_ram_if.sv
// ---------------------------------------------------------------------------
// ddram_resp_ram_if -- read/write burst bus between a DDRAM-style requester
// (master) and the ddram_resp_ram responder (slave).
//
// Handshake semantics, used identically by both channels:
//   * rd_req / wr_req are levels. The slave samples them on every rising
//     edge; a request is accepted on the edge where the slave takes it.
//   * rd_ack / wr_ack are one-cycle pulses, registered. They are high in the
//     cycle right after the accepting edge.
//   * Writes: wr_data / wr_be for the current beat are sampled on each
//     accepting edge. wr_ack is high the following cycle, once per beat.
//   * Reads: rd_data_valid marks one beat per cycle. rd_data holds its last
//     value while rd_data_valid is low.
//
// Signals:
//   rd_addr[28:0], rd_burstcnt[7:0], rd_req        master -> slave
//   rd_ack, rd_data[63:0], rd_data_valid           slave  -> master
//   wr_addr[28:0], wr_burstcnt[7:0], wr_data[63:0],
//   wr_be[7:0], wr_req                             master -> slave
//   wr_ack, wr_busy                                slave  -> master
// ---------------------------------------------------------------------------
interface ddram_resp_ram_if;
  logic [28:0] rd_addr;
  logic [7:0]  rd_burstcnt;
  logic        rd_req;
  logic        rd_ack;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic [28:0] wr_addr;
  logic [7:0]  wr_burstcnt;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        wr_req;
  logic        wr_ack;
  logic        wr_busy;

  modport master (
    output rd_addr, rd_burstcnt, rd_req,
    input  rd_ack, rd_data, rd_data_valid,
    output wr_addr, wr_burstcnt, wr_data, wr_be, wr_req,
    input  wr_ack, wr_busy
  );

  modport slave (
    input  rd_addr, rd_burstcnt, rd_req,
    output rd_ack, rd_data, rd_data_valid,
    input  wr_addr, wr_burstcnt, wr_data, wr_be, wr_req,
    output wr_ack, wr_busy
  );
endinterface

// File: rtl/ddram_resp_ram.sv
// ---------------------------------------------------------------------------
// ddram_resp_ram -- DDRAM-style burst responder backed by a 64-bit RAM window.
//
// A 2^ADDR_BITS x 64-bit RAM answers qword addresses in
// [BASE, BASE + 2^ADDR_BITS). One transaction runs at a time; a write wins
// over a read requested in the same cycle. Out-of-window beats still
// complete (reads return zero, writes are dropped) and set the sticky
// addr_err flag.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   bus            ddram_resp_ram_if.slave (read and write channels)
//   addr_err       sticky out-of-window flag
//   rd_beats       wrapping count of rd_data_valid beats
//   wr_beats       wrapping count of accepted write beats
//   dbg_state      current FSM state (S_IDLE=0, S_WR_BEAT=1, S_RD_LAT=2,
//                  S_RD_STREAM=3)
//
// Build option: define DDRAM_RESP_STALL_EN to add LFSR-driven stall cycles
// that defer acceptance and insert gaps into read streams.
// ---------------------------------------------------------------------------
module ddram_resp_ram #(
  parameter int          ADDR_BITS  = 10,
  parameter logic [28:0] BASE       = 29'h06040000,
  parameter int          RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ddram_resp_ram_if.slave        bus,
  output logic                   addr_err,
  output logic [15:0]            rd_beats,
  output logic [15:0]            wr_beats,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WR_BEAT   = 2'd1,
    S_RD_LAT    = 2'd2,
    S_RD_STREAM = 2'd3
  } state_t;

  // 30-bit address math so BASE + depth and addr + beat never overflow.
  localparam logic [29:0] BASE_EXT = {1'b0, BASE};
  localparam logic [29:0] DEPTH    = 30'(1) << ADDR_BITS;

  logic [63:0] mem [2**ADDR_BITS];

  state_t      state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  lat_q, lat_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_valid_q, rd_valid_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic [15:0] rd_beats_q, rd_beats_d;
  logic [15:0] wr_beats_q, wr_beats_d;

  logic                 stall;
  logic                 wr_beat, rd_emit;
  logic                 mem_we;
  logic [29:0]          cur_addr, cur_off;
  logic                 cur_in_win;
  logic [ADDR_BITS-1:0] cur_idx;

`ifdef DDRAM_RESP_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; a stall cycle whenever the low two bits are zero.
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  function automatic logic [7:0] last_of(input logic [7:0] cnt);
    // A burst count of 0 behaves as a single beat.
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

  // Beat 0 of a write is taken straight from the bus while idle; every other
  // beat (reads and later write beats) comes from the captured base + index.
  always_comb begin
    cur_addr = {1'b0, addr_q} + {22'd0, idx_q};
    if (state_q == S_IDLE) cur_addr = {1'b0, bus.wr_addr};
  end

  assign cur_off    = cur_addr - BASE_EXT;
  assign cur_in_win = (cur_addr >= BASE_EXT) && (cur_off < DEPTH);
  assign cur_idx    = cur_off[ADDR_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    rd_beats_d = rd_beats_q;
    wr_beats_d = wr_beats_q;
    wr_beat    = 1'b0;
    rd_emit    = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!stall) begin
          if (bus.wr_req) begin
            addr_d  = bus.wr_addr;
            last_d  = last_of(bus.wr_burstcnt);
            idx_d   = 8'd1;
            wr_beat = 1'b1;
            state_d = (last_of(bus.wr_burstcnt) != 8'd0) ? S_WR_BEAT : S_IDLE;
          end else if (bus.rd_req) begin
            addr_d   = bus.rd_addr;
            last_d   = last_of(bus.rd_burstcnt);
            idx_d    = 8'd0;
            lat_d    = 4'(RD_LATENCY - 1);
            rd_ack_d = 1'b1;
            state_d  = S_RD_LAT;
          end
        end
      end
      S_WR_BEAT: begin
        if (bus.wr_req && !stall) begin
          wr_beat = 1'b1;
          idx_d   = idx_q + 8'd1;
          if (idx_q == last_q) state_d = S_IDLE;
        end
      end
      S_RD_LAT: begin
        // Beat 0 is registered on the last latency cycle so it appears
        // exactly RD_LATENCY cycles after rd_ack.
        if (lat_q == 4'd0) begin
          rd_emit = 1'b1;
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == last_q) ? S_IDLE : S_RD_STREAM;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RD_STREAM: begin
        if (!stall) begin
          rd_emit = 1'b1;
          idx_d   = idx_q + 8'd1;
          if (idx_q == last_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_beat) begin
      wr_ack_d   = 1'b1;
      wr_beats_d = wr_beats_q + 16'd1;
      mem_we     = cur_in_win && !reset;
      if (!cur_in_win) err_d = 1'b1;
    end

    if (rd_emit) begin
      rd_valid_d = 1'b1;
      rd_data_d  = cur_in_win ? mem[cur_idx] : 64'h0;
      rd_beats_d = rd_beats_q + 16'd1;
      if (!cur_in_win) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
    end
  end

  // RAM contents survive reset; only enabled bytes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wr_be[b]) mem[cur_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  assign bus.rd_ack        = rd_ack_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.wr_ack        = wr_ack_q;
  assign bus.wr_busy       = (state_q == S_WR_BEAT);
  assign addr_err          = err_q;
  assign rd_beats          = rd_beats_q;
  assign wr_beats          = wr_beats_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_ddram_resp_ram.sv
// ---------------------------------------------------------------------------
// tb_ddram_resp_ram -- directed self-checking bench for ddram_resp_ram with
// default parameters (ADDR_BITS=10, BASE=29'h06040000, RD_LATENCY=2).
// ---------------------------------------------------------------------------
module tb_ddram_resp_ram;

  localparam logic [28:0] BASE   = 29'h06040000;
  localparam int          RD_LAT = 2;

  logic        clk;
  logic        reset;
  logic        addr_err;
  logic [15:0] rd_beats;
  logic [15:0] wr_beats;
  logic [1:0]  dbg_state;

  ddram_resp_ram_if bus ();

  ddram_resp_ram dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .addr_err  (addr_err),
    .rd_beats  (rd_beats),
    .wr_beats  (wr_beats),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [15:0] exp_rd_beats = 16'd0;
  logic [15:0] exp_wr_beats = 16'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_ack"},   64'(bus.rd_ack),        64'd0);
    chk({tag, "_rd_data"},  bus.rd_data,            64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.rd_data_valid), 64'd0);
    chk({tag, "_wr_ack"},   64'(bus.wr_ack),        64'd0);
    chk({tag, "_wr_busy"},  64'(bus.wr_busy),       64'd0);
    chk({tag, "_addr_err"}, 64'(addr_err),          64'd0);
    chk({tag, "_rd_beats"}, 64'(rd_beats),          64'd0);
    chk({tag, "_wr_beats"}, 64'(wr_beats),          64'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_rd_beats"}, 64'(rd_beats), 64'(exp_rd_beats));
    chk({tag, "_wr_beats"}, 64'(wr_beats), 64'(exp_wr_beats));
  endtask

  // ---------------- drivers ----------------
  // Beat k carries d0 + k*inc; one beat per cycle.
  task automatic write_burst(input logic [28:0] a, input logic [7:0] n,
                             input logic [63:0] d0, input logic [63:0] inc,
                             input logic [7:0] be);
    int eff;
    eff = (n == 8'd0) ? 1 : int'(n);
    bus.wr_addr     = a;
    bus.wr_burstcnt = n;
    bus.wr_be       = be;
    bus.wr_req      = 1'b1;
    for (int k = 0; k < eff; k++) begin
      bus.wr_data = d0 + 64'(k) * inc;
      step();
      chk("wr_ack_beat", 64'(bus.wr_ack), 64'd1);
      exp_wr_beats++;
      if (k < eff - 1) chk("wr_busy_mid", 64'(bus.wr_busy), 64'd1);
    end
    bus.wr_req = 1'b0;
    chk("wr_busy_end", 64'(bus.wr_busy), 64'd0);
    step();
    chk("wr_ack_end", 64'(bus.wr_ack), 64'd0);
  endtask

  // Expected beats are taken from exp_q in order.
  task automatic read_burst(input logic [28:0] a, input logic [7:0] n);
    int          eff;
    logic [63:0] last_d;
    eff = (n == 8'd0) ? 1 : int'(n);
    last_d = '0;
    bus.rd_addr     = a;
    bus.rd_burstcnt = n;
    bus.rd_req      = 1'b1;
    step();
    chk("rd_ack", 64'(bus.rd_ack), 64'd1);
    bus.rd_req = 1'b0;
    for (int i = 1; i < RD_LAT; i++) begin
      step();
      chk("rd_lat_gap", 64'(bus.rd_data_valid), 64'd0);
    end
    step();
    for (int k = 0; k < eff; k++) begin
      last_d = exp_q.pop_front();
      chk("rd_valid_beat", 64'(bus.rd_data_valid), 64'd1);
      chk("rd_data_beat", bus.rd_data, last_d);
      exp_rd_beats++;
      step();
    end
    chk("rd_valid_end", 64'(bus.rd_data_valid), 64'd0);
    chk("rd_data_hold", bus.rd_data, last_d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset           = 1'b1;
    bus.rd_addr     = '0;
    bus.rd_burstcnt = '0;
    bus.rd_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_burstcnt = '0;
    bus.wr_data     = '0;
    bus.wr_be       = '0;
    bus.wr_req      = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Single-beat write then read, latency RD_LAT after rd_ack.
    write_burst(BASE + 29'd1, 8'd1, 64'h0000000100000001, 64'd0, 8'hFF);
    exp_q.push_back(64'h0000000100000001);
    read_burst(BASE + 29'd1, 8'd1);
    chk_counts("single");

    // 4-beat burst, gapless read back.
    write_burst(BASE + 29'd8, 8'd4, 64'd1, 64'd1, 8'hFF);
    for (int k = 1; k <= 4; k++) exp_q.push_back(64'(k));
    read_burst(BASE + 29'd8, 8'd4);
    chk_counts("burst4");

    // Byte enables: low half cleared, then a be=0 write changes nothing.
    write_burst(BASE + 29'd20, 8'd1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 8'hFF);
    write_burst(BASE + 29'd20, 8'd1, 64'h0, 64'd0, 8'h0F);
    exp_q.push_back(64'hFFFFFFFF00000000);
    read_burst(BASE + 29'd20, 8'd1);
    write_burst(BASE + 29'd20, 8'd1, 64'h1234, 64'd0, 8'h00);
    exp_q.push_back(64'hFFFFFFFF00000000);
    read_burst(BASE + 29'd20, 8'd1);
    chk_counts("byte_en");

    // Simultaneous requests: write first, read returns new data.
    bus.wr_addr     = BASE + 29'd30;
    bus.wr_burstcnt = 8'd1;
    bus.wr_data     = 64'hDEADBEEFCAFEF00D;
    bus.wr_be       = 8'hFF;
    bus.wr_req      = 1'b1;
    bus.rd_addr     = BASE + 29'd30;
    bus.rd_burstcnt = 8'd1;
    bus.rd_req      = 1'b1;
    step();
    chk("simul_wr_ack", 64'(bus.wr_ack), 64'd1);
    chk("simul_rd_ack_early", 64'(bus.rd_ack), 64'd0);
    exp_wr_beats++;
    bus.wr_req = 1'b0;
    step();
    chk("simul_rd_ack", 64'(bus.rd_ack), 64'd1);
    bus.rd_req = 1'b0;
    step();
    chk("simul_gap", 64'(bus.rd_data_valid), 64'd0);
    step();
    chk("simul_valid", 64'(bus.rd_data_valid), 64'd1);
    chk("simul_data", bus.rd_data, 64'hDEADBEEFCAFEF00D);
    exp_rd_beats++;
    step();
    chk("in_window_no_err", 64'(addr_err), 64'd0);

    // Window end crossing, aliasing write and below-window read.
    write_burst(BASE + 29'd1022, 8'd2, 64'hA0, 64'd1, 8'hFF);
    exp_q.push_back(64'hA0);
    exp_q.push_back(64'hA1);
    exp_q.push_back(64'h0);
    read_burst(BASE + 29'd1022, 8'd3);
    chk("cross_addr_err", 64'(addr_err), 64'd1);
    write_burst(BASE, 8'd1, 64'h77, 64'd0, 8'hFF);
    write_burst(BASE + 29'd1024, 8'd1, 64'h55, 64'd0, 8'hFF);
    exp_q.push_back(64'h77);
    read_burst(BASE, 8'd1);
    exp_q.push_back(64'h0);
    read_burst(BASE - 29'd1, 8'd1);
    chk_counts("window");

    // Reset in the middle of an 8-beat read.
    write_burst(BASE + 29'd100, 8'd8, 64'h100, 64'd1, 8'hFF);
    bus.rd_addr     = BASE + 29'd100;
    bus.rd_burstcnt = 8'd8;
    bus.rd_req      = 1'b1;
    step();
    chk("rst_rd_ack", 64'(bus.rd_ack), 64'd1);
    bus.rd_req = 1'b0;
    step();
    step();
    chk("rst_beat0", bus.rd_data, 64'h100);
    step();
    chk("rst_beat1", bus.rd_data, 64'h101);
    reset = 1'b1;
    exp_rd_beats = 16'd0;
    exp_wr_beats = 16'd0;
    step();
    chk_all_zero("mid_reset");
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_reset_valid", 64'(bus.rd_data_valid), 64'd0);
    end
    write_burst(BASE + 29'd5, 8'd1, 64'h5555, 64'd0, 8'hFF);
    exp_q.push_back(64'h5555);
    read_burst(BASE + 29'd5, 8'd1);
    exp_q.push_back(64'h0000000100000001);
    read_burst(BASE + 29'd1, 8'd1);
    chk_counts("after_reset");

    // Burst count 0 acts as one beat on both channels.
    write_burst(BASE + 29'd6, 8'd0, 64'h66, 64'd0, 8'hFF);
    exp_q.push_back(64'h66);
    read_burst(BASE + 29'd6, 8'd0);
    chk_counts("burst0");
    chk("final_addr_err", 64'(addr_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddram_resp_ram.md
DDRAM_RESP_RAM -- requirements
Module: ddram_resp_ram

Interface
REQ-001 Parameter ADDR_BITS, default 10, log2 of the window depth in 64-bit qwords (1024 qwords).
REQ-002 Parameter BASE, default 29'h06040000, first qword address of the window.
REQ-003 Parameter RD_LATENCY, default 2, cycles from rd_ack to the first rd_data_valid; legal range 1..15.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 rd_addr  in  29  read qword address; rd_burstcnt  in  8  read beats; rd_req  in  1  read request, level, held until rd_ack.
REQ-006 rd_ack  out  1  one-cycle read accept; rd_data  out  64  read beat data; rd_data_valid  out  1  read beat strobe.
REQ-007 wr_addr  in  29  write qword address; wr_burstcnt  in  8  write beats; wr_data  in  64  write data; wr_be  in  8  byte enables; wr_req  in  1  write request, level.
REQ-008 wr_ack  out  1  one-cycle per-beat write accept; wr_busy  out  1  write burst in progress.
REQ-009 addr_err  out  1  sticky out-of-window access flag; rd_beats / wr_beats  out  16 each  wrapping beat counters.

Function
REQ-010 Storage: 2^ADDR_BITS x 64-bit RAM; a qword address A is in the window iff BASE <= A < BASE + 2^ADDR_BITS; index = A - BASE, truncated to ADDR_BITS bits.
REQ-011 FSM states: S_IDLE, S_WR_BEAT, S_RD_LAT, S_RD_STREAM; one transaction at a time, no overlap of reads and writes.
REQ-012 S_IDLE with wr_req=1: capture wr_addr/wr_burstcnt, write beat 0 using wr_data/wr_be, pulse wr_ack that cycle +1, and go to S_WR_BEAT if more beats remain, else stay in S_IDLE.
REQ-013 Simultaneous rd_req and wr_req in S_IDLE: the write wins; the read is served after the write burst completes.
REQ-014 S_WR_BEAT: wr_busy=1; on each cycle with wr_req=1, write the next beat at the captured address + beat index and pulse wr_ack the next cycle; after the last beat return to S_IDLE with wr_busy=0.
REQ-015 Byte enables: only bytes with wr_be[i]=1 update bits [8i+7:8i]; wr_be=0 performs no RAM change but still acks and counts.
REQ-016 S_IDLE with rd_req=1 and no wr_req: capture rd_addr/rd_burstcnt, pulse rd_ack the next cycle, and go to S_RD_LAT.
REQ-017 First rd_data_valid occurs exactly RD_LATENCY cycles after rd_ack.
REQ-018 S_RD_STREAM: rd_data_valid is high on consecutive cycles, one beat per cycle, for exactly burstcnt beats, carrying data for address + 0, 1, 2, ...; then return to S_IDLE.
REQ-019 rd_data holds its last value when rd_data_valid=0.
REQ-020 burstcnt 0 is treated as 1, for both reads and writes.
REQ-021 Out-of-window beats, including bursts crossing the window end: reads return 64'h0 and writes are dropped; each such beat sets addr_err, and the beat is still acked or validated normally.
REQ-022 rd_beats increments per rd_data_valid beat and wr_beats per wr_ack beat, both modulo 2^16.
REQ-023 Read-after-write: a read accepted after the final wr_ack of a write returns the written data.
REQ-024 A request whose req drops before its ack is still completed once accepted; a request dropped before acceptance is ignored.

Reset
REQ-025 On reset all outputs go to 0 (rd_ack, rd_data, rd_data_valid, wr_ack, wr_busy, addr_err, rd_beats, wr_beats), the FSM goes to S_IDLE, and any in-flight burst is abandoned.
REQ-026 RAM contents are not cleared by reset.
REQ-027 A burst interrupted by reset emits no further beats after reset deasserts.

Configuration
REQ-028 With macro DDRAM_RESP_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1 at reset, taps 16,14,13,11) advances every cycle.
REQ-029 With DDRAM_RESP_STALL_EN defined: when LFSR[1:0]==0, acceptance in S_IDLE and each S_WR_BEAT beat are deferred that cycle.
REQ-030 With DDRAM_RESP_STALL_EN defined: a stall cycle also holds rd_data_valid low for one cycle mid-stream.
REQ-031 With DDRAM_RESP_STALL_EN undefined: no stalls occur; timing is exactly as in REQ-012..REQ-018.

Verification
REQ-032 Write 64'h0000000100000001 at BASE+1 (be=FF), then read BASE+1 burst 1: rd_ack, then valid 2 cycles later with the same data; rd_beats=1, wr_beats=1.
REQ-033 Write 4-beat burst at BASE+8 with data 1,2,3,4, then read burst 4: four consecutive valids with 1,2,3,4 and no gaps (stall macro off).
REQ-034 Write 64'hFFFF... with be=FF, then 64'h0 with be=0F at the same address: read returns 64'hFFFFFFFF00000000.
REQ-035 rd_req and wr_req asserted in the same cycle: wr_ack precedes rd_ack, and the read returns the newly written data.
REQ-036 Read burst 3 at BASE+1022 (ADDR_BITS=10): beats return RAM[1022], RAM[1023], then 0; addr_err=1.
REQ-037 Reset asserted during beat 2 of a read burst of 8: no rd_data_valid after reset; all outputs are 0; a new request afterwards is served normally.
